// File: rtl/mem_fault_guard_if.sv
// Bus bundle between the CPU memory stage, data memory, the fault handler
// and mem_fault_guard. The guard uses the slave view; the surrounding
// system (CPU, memory, handler) uses the master view.
interface mem_fault_guard_if;
  // CPU request side
  logic        req_valid;
  logic        req_write;
  logic [15:0] Addr;
  logic [15:0] WData;
  logic [15:0] PC;
  logic        segment;
  logic        req_ready;
  logic [15:0] RData;
  logic        rdata_valid;
  // Data memory side
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  // Fault reporting side
  logic        fault_pending;
  logic [1:0]  fault_cause;
  logic [15:0] FaultAddr;
  logic [15:0] FaultPC;
  logic        fault_write;
  logic        fault_ack;
  logic [7:0]  fault_count;

  modport slave (
    input  req_valid, req_write, Addr, WData, PC, segment,
    output req_ready, RData, rdata_valid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output fault_pending, fault_cause, FaultAddr, FaultPC, fault_write,
    input  fault_ack,
    output fault_count
  );

  modport master (
    output req_valid, req_write, Addr, WData, PC, segment,
    input  req_ready, RData, rdata_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  fault_pending, fault_cause, FaultAddr, FaultPC, fault_write,
    output fault_ack,
    input  fault_count
  );
endinterface

// File: rtl/mem_fault_guard.sv
// Memory-stage guard: forwards legal requests to data memory with a
// ready/wait handshake and wait-state timeout, and turns illegal requests
// (address-checker verdict) or timeouts into a latched, acknowledged fault.
// No memory strobe is issued for a request flagged by the address checker.
module mem_fault_guard #(
  parameter int TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               nReset,
  mem_fault_guard_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_SEGMENT = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  // The access times out on the TIMEOUT-th cycle without mem_ready, i.e.
  // when the counter of earlier wait cycles already equals TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST     = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] req_pc;       // PC of the in-flight access, for timeout faults

  logic        req_ready_r;
  logic [15:0] rdata_r;
  logic        rdata_valid_r;
  logic        mem_en_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic        fault_pending_r;
  logic [1:0]  fault_cause_r;
  logic [15:0] fault_addr_r;
  logic [15:0] fault_pc_r;
  logic        fault_write_r;
  logic [7:0]  fault_count_r;

  // Saturating 8-bit increment for the fault counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  // Guard FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      req_pc          <= '0;
      req_ready_r     <= 1'b1;
      rdata_r         <= '0;
      rdata_valid_r   <= 1'b0;
      mem_en_r        <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_addr_r      <= '0;
      mem_wdata_r     <= '0;
      fault_pending_r <= 1'b0;
      fault_cause_r   <= '0;
      fault_addr_r    <= '0;
      fault_pc_r      <= '0;
      fault_write_r   <= 1'b0;
      fault_count_r   <= '0;
    end else begin
      rdata_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            if (bus.segment) begin
              // Illegal address: report it, never touch memory.
              fault_addr_r    <= bus.Addr;
              fault_pc_r      <= bus.PC;
              fault_write_r   <= bus.req_write;
              fault_cause_r   <= CAUSE_SEGMENT;
              fault_pending_r <= 1'b1;
              fault_count_r   <= sat_inc8(fault_count_r);
              state           <= FAULT;
            end else begin
              mem_addr_r  <= bus.Addr;
              mem_wdata_r <= bus.WData;
              mem_we_r    <= bus.req_write;
              req_pc      <= bus.PC;
              mem_en_r    <= 1'b1;
              wait_cnt    <= '0;
              state       <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (bus.mem_ready) begin
            // Completion beats a timeout landing in the same cycle.
            if (!mem_we_r) begin
              rdata_r       <= bus.mem_rdata;
              rdata_valid_r <= 1'b1;
            end
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            req_ready_r <= 1'b1;
            wait_cnt    <= '0;
            state       <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            fault_addr_r    <= mem_addr_r;
            fault_pc_r      <= req_pc;
            fault_write_r   <= mem_we_r;
            fault_cause_r   <= CAUSE_TIMEOUT;
            fault_pending_r <= 1'b1;
            fault_count_r   <= sat_inc8(fault_count_r);
            mem_en_r        <= 1'b0;
            mem_we_r        <= 1'b0;
            wait_cnt        <= '0;
            state           <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        FAULT: begin
          // Requests are ignored here; the CPU re-presents them in IDLE.
          if (bus.fault_ack) begin
            fault_pending_r <= 1'b0;
            req_ready_r     <= 1'b1;
            state           <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready_r <= 1'b1;
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_r;
  assign bus.RData         = rdata_r;
  assign bus.rdata_valid   = rdata_valid_r;
  assign bus.mem_en        = mem_en_r;
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.fault_pending = fault_pending_r;
  assign bus.fault_cause   = fault_cause_r;
  assign bus.FaultAddr     = fault_addr_r;
  assign bus.FaultPC       = fault_pc_r;
  assign bus.fault_write   = fault_write_r;
  assign bus.fault_count   = fault_count_r;

endmodule

// File: tb/tb_mem_fault_guard.sv
// Directed bench for mem_fault_guard with TIMEOUT = 4.
module tb_mem_fault_guard;

  logic CLK;
  logic nReset;
  int   n_vec;
  int   n_err;
  int   en_cycles;
  int   rv_seen;

  mem_fault_guard_if bus ();

  mem_fault_guard #(.TIMEOUT(4)) dut (
    .CLK    (CLK),
    .nReset (nReset),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.Addr      = '0;
    bus.WData     = '0;
    bus.PC        = '0;
    bus.segment   = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.fault_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    nReset = 1'b0;
    idle_inputs();

    // Reset state
    #12;
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_val("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check_val("rst_fault_pending", 32'(bus.fault_pending), 32'd0);
    check_val("rst_fault_count", 32'(bus.fault_count), 32'd0);
    check_val("rst_rdata", 32'(bus.RData), 32'd0);
    nReset = 1'b1;
    tick();

    // Segment violation on a load
    bus.req_valid = 1'b1;
    bus.Addr      = 16'hc3ff;
    bus.PC        = 16'h0040;
    bus.segment   = 1'b1;
    check_val("seg_mem_en_pre", 32'(bus.mem_en), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    bus.segment   = 1'b0;
    check_val("seg_pending", 32'(bus.fault_pending), 32'd1);
    check_val("seg_cause", 32'(bus.fault_cause), 32'h1);
    check_val("seg_faddr", 32'(bus.FaultAddr), 32'hc3ff);
    check_val("seg_fpc", 32'(bus.FaultPC), 32'h0040);
    check_val("seg_fwrite", 32'(bus.fault_write), 32'd0);
    check_val("seg_count", 32'(bus.fault_count), 32'd1);
    check_val("seg_mem_en", 32'(bus.mem_en), 32'd0);
    check_val("seg_req_ready", 32'(bus.req_ready), 32'd0);

    // Ack together with a legal request: only the ack takes effect
    bus.fault_ack = 1'b1;
    bus.req_valid = 1'b1;
    bus.Addr      = 16'h0100;
    bus.PC        = 16'h0044;
    tick();
    bus.fault_ack = 1'b0;
    check_val("ack_pending", 32'(bus.fault_pending), 32'd0);
    check_val("ack_req_ready", 32'(bus.req_ready), 32'd1);
    check_val("ack_not_accepted", 32'(bus.mem_en), 32'd0);
    check_val("ack_faddr_hold", 32'(bus.FaultAddr), 32'hc3ff);

    // Legal load, zero wait: request still presented, accepted now
    tick();
    bus.req_valid = 1'b0;
    bus.segment   = 1'b1;   // checker verdict after acceptance must not matter
    check_val("ld_mem_en", 32'(bus.mem_en), 32'd1);
    check_val("ld_mem_we", 32'(bus.mem_we), 32'd0);
    check_val("ld_mem_addr", 32'(bus.mem_addr), 32'h0100);
    check_val("ld_req_ready", 32'(bus.req_ready), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hbeef;
    tick();
    bus.mem_ready = 1'b0;
    bus.segment   = 1'b0;
    check_val("ld_rvalid", 32'(bus.rdata_valid), 32'd1);
    check_val("ld_rdata", 32'(bus.RData), 32'hbeef);
    check_val("ld_mem_en_off", 32'(bus.mem_en), 32'd0);
    check_val("ld_req_ready_back", 32'(bus.req_ready), 32'd1);
    check_val("ld_no_fault", 32'(bus.fault_pending), 32'd0);
    tick();
    check_val("ld_rvalid_pulse", 32'(bus.rdata_valid), 32'd0);
    check_val("ld_rdata_hold", 32'(bus.RData), 32'hbeef);

    // Legal store, 3 wait states
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.Addr      = 16'h0200;
    bus.WData     = 16'h1234;
    bus.PC        = 16'h0050;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    en_cycles = 0;
    rv_seen   = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_en && bus.mem_we) en_cycles++;
      if (bus.rdata_valid) rv_seen++;
      if (i == 0) begin
        check_val("st_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        check_val("st_mem_addr", 32'(bus.mem_addr), 32'h0200);
      end
      bus.mem_ready = (i == 3);
      tick();
    end
    bus.mem_ready = 1'b0;
    check_val("st_strobe_cycles", 32'(en_cycles), 32'd4);
    check_val("st_no_rvalid", 32'(rv_seen), 32'd0);
    check_val("st_no_fault", 32'(bus.fault_pending), 32'd0);
    check_val("st_req_ready", 32'(bus.req_ready), 32'd1);

    // Timeout: mem_ready held low for TIMEOUT = 4 cycles
    bus.req_valid = 1'b1;
    bus.Addr      = 16'h0300;
    bus.PC        = 16'h0088;
    tick();
    bus.req_valid = 1'b0;
    en_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_en) en_cycles++;
      if (i == 3) check_val("to_pending_early", 32'(bus.fault_pending), 32'd0);
      tick();
    end
    check_val("to_strobe_cycles", 32'(en_cycles), 32'd4);
    check_val("to_pending", 32'(bus.fault_pending), 32'd1);
    check_val("to_cause", 32'(bus.fault_cause), 32'h2);
    check_val("to_mem_en", 32'(bus.mem_en), 32'd0);
    check_val("to_faddr", 32'(bus.FaultAddr), 32'h0300);
    check_val("to_fpc", 32'(bus.FaultPC), 32'h0088);
    check_val("to_count", 32'(bus.fault_count), 32'd2);
    bus.fault_ack = 1'b1;
    tick();
    bus.fault_ack = 1'b0;
    check_val("to_ack_ready", 32'(bus.req_ready), 32'd1);

    // Companion: mem_ready in the 4th access cycle completes normally
    bus.req_valid = 1'b1;
    bus.Addr      = 16'h0400;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      bus.mem_rdata = 16'h5a5a;
      tick();
    end
    bus.mem_ready = 1'b0;
    check_val("tc_no_fault", 32'(bus.fault_pending), 32'd0);
    check_val("tc_rvalid", 32'(bus.rdata_valid), 32'd1);
    check_val("tc_rdata", 32'(bus.RData), 32'h5a5a);
    check_val("tc_count", 32'(bus.fault_count), 32'd2);
    tick();

    // 260 consecutive segment faults, each acknowledged: count saturates
    for (int j = 0; j < 260; j++) begin
      bus.req_valid = 1'b1;
      bus.segment   = 1'b1;
      bus.Addr      = 16'(j);
      tick();
      bus.req_valid = 1'b0;
      bus.segment   = 1'b0;
      if (j == 0)   check_val("sat_count_3", 32'(bus.fault_count), 32'd3);
      if (j == 251) check_val("sat_count_254", 32'(bus.fault_count), 32'd254);
      if (j == 252) check_val("sat_count_255", 32'(bus.fault_count), 32'd255);
      bus.fault_ack = 1'b1;
      tick();
      bus.fault_ack = 1'b0;
    end
    check_val("sat_count_final", 32'(bus.fault_count), 32'd255);
    check_val("sat_last_faddr", 32'(bus.FaultAddr), 32'd259);

    // Asynchronous reset in the middle of an access
    bus.req_valid = 1'b1;
    bus.Addr      = 16'h0500;
    tick();
    bus.req_valid = 1'b0;
    check_val("ar_mem_en_before", 32'(bus.mem_en), 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    check_val("ar_mem_en", 32'(bus.mem_en), 32'd0);
    check_val("ar_req_ready", 32'(bus.req_ready), 32'd1);
    check_val("ar_count", 32'(bus.fault_count), 32'd0);
    check_val("ar_faddr", 32'(bus.FaultAddr), 32'd0);
    check_val("ar_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("ar_rdata", 32'(bus.RData), 32'd0);
    nReset = 1'b1;
    tick();

    // Asynchronous reset while a fault is pending
    bus.req_valid = 1'b1;
    bus.segment   = 1'b1;
    bus.Addr      = 16'h0600;
    tick();
    bus.req_valid = 1'b0;
    bus.segment   = 1'b0;
    check_val("fr_pending_before", 32'(bus.fault_pending), 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    check_val("fr_pending", 32'(bus.fault_pending), 32'd0);
    check_val("fr_cause", 32'(bus.fault_cause), 32'd0);
    check_val("fr_req_ready", 32'(bus.req_ready), 32'd1);
    nReset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
